prog_loader: RTL

- Writer side of the processor's instruction memory: receives a program as a stream of BIT_WIDTH-wide beats, assembles instructions, writes them into program RAM, then releases the core to run.
- Replaces file-based ROM preload for hardware bring-up.
- Sits between an external host link (UART/debug shim) and the instruction memory write port; also gates the core's run enable.

---
 rtl/prog_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader
// -----------
// Writer side of the processor's instruction memory. A host link streams a
// program as BIT_WIDTH-wide beats. The loader assembles them into
// INSTR_WIDTH-wide instructions and writes each one into program RAM. Once
// the trailing checksum verifies, it releases the core through cpu_en.
//
// Session stream layout (each field is sent MSB beat first):
//   header   : ceil(ADDR_WIDTH/BIT_WIDTH) beats carrying the instruction count L
//   payload  : L instructions of BEATS beats each (summed into the checksum)
//   checksum : one beat, the modulo-2^BIT_WIDTH sum of all payload beats
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   one-cycle request to begin a load session
//   in_data    in   stream beat
//   in_valid   in   in_data is valid
//   in_ready   out  loader accepts a beat this cycle (registered)
//   mem_we     out  instruction memory write strobe (one cycle per word)
//   mem_addr   out  instruction memory write address
//   mem_wdata  out  instruction memory write data
//   cpu_en     out  processor run enable, high only after a verified load
//   done       out  load verified
//   err        out  load failed (zero length or checksum mismatch)

module prog_loader #(
  parameter int BIT_WIDTH  = 4,
  parameter int BEATS      = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIT_WIDTH-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [BIT_WIDTH*BEATS-1:0]    mem_wdata,
  output logic                          cpu_en,
  output logic                          done,
  output logic                          err
);

  localparam int INSTR_WIDTH = BIT_WIDTH * BEATS;
  // The length is carried in as many beats as it takes to cover ADDR_WIDTH bits.
  localparam int HDR_BEATS   = (ADDR_WIDTH + BIT_WIDTH - 1) / BIT_WIDTH;
  localparam int HDR_WIDTH   = HDR_BEATS * BIT_WIDTH;
  localparam int CNT_WIDTH   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t                   state_q,     state_d;
  logic [CNT_WIDTH-1:0]     hdr_cnt_q,   hdr_cnt_d;
  logic [CNT_WIDTH-1:0]     beat_cnt_q,  beat_cnt_d;
  logic [HDR_WIDTH-1:0]     len_q,       len_d;
  logic [INSTR_WIDTH-1:0]   asm_q,       asm_d;
  logic [ADDR_WIDTH-1:0]    addr_q,      addr_d;
  logic [BIT_WIDTH-1:0]     cksum_q,     cksum_d;
  logic                     in_ready_q,  in_ready_d;
  logic                     mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q,  mem_addr_d;
  logic [INSTR_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                     done_q,      done_d;
  logic                     err_q,       err_d;
  logic                     cpu_en_q,    cpu_en_d;

  logic                     accept;
  logic [ADDR_WIDTH-1:0]    len_words;

  // A beat moves only when the registered ready and the host's valid coincide.
  assign accept    = in_valid && in_ready_q;
  assign len_words = len_q[ADDR_WIDTH-1:0];

  // State and datapath registers. Reset drops any pending write strobe
  // immediately but leaves the memory itself untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hdr_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      asm_q       <= '0;
      addr_q      <= '0;
      cksum_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      asm_q       <= asm_d;
      addr_q      <= addr_d;
      cksum_q     <= cksum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_en_q    <= cpu_en_d;
    end
  end

  // Next-state and datapath logic. Partial header/instruction state is only
  // touched on an accepted beat, so a stalled stream simply holds.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    len_d       = len_q;
    asm_d       = asm_q;
    addr_d      = addr_q;
    cksum_d     = cksum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          hdr_cnt_d  = '0;
          beat_cnt_d = '0;
          len_d      = '0;
          asm_d      = '0;
          addr_d     = '0;
          cksum_d    = '0;
        end
      end

      S_HDR: begin
        if (accept) begin
          len_d = (len_q << BIT_WIDTH) | HDR_WIDTH'(in_data);
          if (hdr_cnt_q == CNT_WIDTH'(HDR_BEATS - 1)) begin
            hdr_cnt_d = '0;
            if (len_d[ADDR_WIDTH-1:0] == '0) begin
              state_d = S_ERR;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      S_LOAD: begin
        if (accept) begin
          // Older beats shift out of the top; after BEATS beats the
          // register holds exactly one instruction, MSB beat first.
          asm_d   = (asm_q << BIT_WIDTH) | INSTR_WIDTH'(in_data);
          cksum_d = cksum_q + in_data;
          if (beat_cnt_q == CNT_WIDTH'(BEATS - 1)) begin
            beat_cnt_d  = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = asm_d;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            if (addr_q == len_words - ADDR_WIDTH'(1)) begin
              state_d = S_CHK;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      S_CHK: begin
        if (accept) begin
          if (in_data == cksum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state, so they change on the
  // same edge that moves the FSM (one cycle after the deciding beat).
  always_comb begin
    in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CHK);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_en_d   = (state_d == S_DONE);
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_en    = cpu_en_q;

endmodule
